// File: rtl/vx_csr_pipe_if.sv
// Request/response bundle for the CSR pipe: request channel, fence
// handshake with the issue logic, and the response channel.
interface vx_csr_pipe_if #(
    parameter int NUM_LANES = 4,
    parameter int XLEN      = 32,
    parameter int NW_BITS   = 2,
    parameter int PID_W     = 1,
    parameter int TAG_W     = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [11:0]               req_addr;
    logic                      req_use_imm;
    logic [4:0]                req_imm;
    logic [XLEN-1:0]           req_rs1;
    logic [NW_BITS-1:0]        req_wid;
    logic [PID_W-1:0]          req_pid;
    logic [TAG_W-1:0]          req_tag;

    logic                      alm_empty;
    logic [NW_BITS-1:0]        alm_empty_wid;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [TAG_W-1:0]          rsp_tag;
    logic [NW_BITS-1:0]        rsp_wid;
    logic                      rsp_err;
    logic [NUM_LANES*XLEN-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_addr, req_use_imm, req_imm, req_rs1,
               req_wid, req_pid, req_tag, alm_empty, rsp_ready,
        input  req_ready, alm_empty_wid, rsp_valid, rsp_tag, rsp_wid,
               rsp_err, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_use_imm, req_imm, req_rs1,
               req_wid, req_pid, req_tag, alm_empty, rsp_ready,
        output req_ready, alm_empty_wid, rsp_valid, rsp_tag, rsp_wid,
               rsp_err, rsp_data
    );
endinterface

// File: rtl/vx_csr_pipe.sv
// CSR access pipe: per-warp scratch CSRs, thread/hart ID reads, fencing of
// low addresses until the warp drains, and an in-order response FIFO.
module vx_csr_pipe #(
    parameter int          NUM_LANES   = 4,
    parameter int          NUM_THREADS = 8,
    parameter int          NUM_WARPS   = 4,
    parameter int          XLEN        = 32,
    parameter int          NUM_CSRS    = 8,
    parameter logic [11:0] CSR_BASE    = 12'hBC0,
    parameter logic [11:0] FENCE_LIMIT = 12'h003,
    parameter int          RSP_DEPTH   = 4,
    parameter int          TAG_W       = 8,
    parameter int          CORE_ID     = 0
) (
    input logic         clk,
    input logic         reset,
    vx_csr_pipe_if.slave bus
);
    localparam int PID_BITS   = $clog2(NUM_THREADS / NUM_LANES);
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int TID_BITS   = $clog2(NUM_THREADS);
    localparam int IDX_W      = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;
    localparam int PTR_W      = $clog2(RSP_DEPTH);
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);
    localparam int DATA_W     = NUM_LANES * XLEN;
    localparam int WID_SLOTS  = 1 << NW_BITS;

    typedef enum logic {IDLE = 1'b0, FENCE = 1'b1} state_t;

    state_t             state;
    logic [NW_BITS-1:0] fence_wid;

    logic [XLEN-1:0]    csr_mem [WID_SLOTS][NUM_CSRS];

    logic [TAG_W-1:0]   q_tag  [RSP_DEPTH];
    logic [NW_BITS-1:0] q_wid  [RSP_DEPTH];
    logic               q_err  [RSP_DEPTH];
    logic [DATA_W-1:0]  q_data [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [11:0]        csr_off;
    logic [IDX_W-1:0]   csr_idx;
    logic               is_scratch, is_tid, is_hart, fenced;
    logic [XLEN-1:0]    src, old_val, new_val, lane_base, hart_base;
    logic [DATA_W-1:0]  data_in;
    logic               xfer, pop, do_write;

    // Request decode, operand select and response data formation
    always_comb begin
        csr_off    = bus.req_addr - CSR_BASE;
        csr_idx    = csr_off[IDX_W-1:0];
        is_scratch = (bus.req_addr >= CSR_BASE) && (csr_off < 12'(NUM_CSRS));
        is_tid     = (bus.req_addr == 12'hCC0);
        is_hart    = (bus.req_addr == 12'hF14);
        fenced     = (bus.req_addr <= FENCE_LIMIT);
        src        = bus.req_use_imm ? XLEN'(bus.req_imm) : bus.req_rs1;
        old_val    = csr_mem[bus.req_wid][csr_idx];
        case (bus.req_op)
            2'd0:    new_val = src;
            2'd1:    new_val = old_val | src;
            default: new_val = old_val & ~src;
        endcase
        lane_base = '0;
        if (PID_BITS > 0) lane_base = XLEN'(bus.req_pid) * XLEN'(NUM_LANES);
        hart_base = (XLEN'(CORE_ID) << (NW_BITS + TID_BITS))
                  + (XLEN'(bus.req_wid) << TID_BITS);
        data_in = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (is_scratch)   data_in[i*XLEN +: XLEN] = old_val;
            else if (is_tid)  data_in[i*XLEN +: XLEN] = lane_base + XLEN'(i);
            else if (is_hart) data_in[i*XLEN +: XLEN] = hart_base + lane_base + XLEN'(i);
        end
    end

    // Handshake: a full FIFO blocks even when a pop is in flight this cycle
    always_comb begin
        bus.req_ready     = (state == IDLE) && (count < CNT_W'(RSP_DEPTH))
                          && (!fenced || bus.alm_empty);
        bus.alm_empty_wid = (state == FENCE) ? fence_wid : bus.req_wid;
        xfer              = bus.req_valid && bus.req_ready;
        pop               = bus.rsp_valid && bus.rsp_ready;
        do_write          = xfer && is_scratch && ((bus.req_op == 2'd0) || (src != '0));
    end

    // Fence FSM: park until the issuing warp reports it has drained
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fence_wid <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && fenced && !bus.alm_empty) begin
                    state     <= FENCE;
                    fence_wid <= bus.req_wid;
                end
                FENCE: if (bus.alm_empty) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Scratch CSR storage, written at the transfer edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned w = 0; w < WID_SLOTS; w++)
                for (int unsigned c = 0; c < NUM_CSRS; c++)
                    csr_mem[w][c] <= '0;
        end else if (do_write) begin
            csr_mem[bus.req_wid][csr_idx] <= new_val;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (xfer) wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({xfer, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk) begin
        if (xfer) begin
            q_tag[wr_ptr]  <= bus.req_tag;
            q_wid[wr_ptr]  <= bus.req_wid;
            q_err[wr_ptr]  <= !(is_scratch || is_tid || is_hart);
            q_data[wr_ptr] <= data_in;
        end
    end

    // Head entry drives the response channel; zeroed while empty
    always_comb begin
        bus.rsp_valid = (count != '0);
        bus.rsp_tag   = bus.rsp_valid ? q_tag[rd_ptr]  : '0;
        bus.rsp_wid   = bus.rsp_valid ? q_wid[rd_ptr]  : '0;
        bus.rsp_err   = bus.rsp_valid && q_err[rd_ptr];
        bus.rsp_data  = bus.rsp_valid ? q_data[rd_ptr] : '0;
    end
endmodule

// File: tb/tb_vx_csr_pipe.sv
// Testbench for vx_csr_pipe: table of single requests plus sequences for
// fencing, FIFO back-pressure and reset with pending state.
module tb_vx_csr_pipe;
    localparam int NL = 4, XL = 32, NWB = 2, PIDW = 1, TW = 8, DW = NL * XL;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_csr_pipe_if #(.NUM_LANES(NL), .XLEN(XL), .NW_BITS(NWB), .PID_W(PIDW), .TAG_W(TW)) bus ();

    vx_csr_pipe #(.CORE_ID(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [TW-1:0]  tag;
        logic [NWB-1:0] wid;
        logic           err;
        logic [DW-1:0]  data;
    } rsp_t;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic        ui;
        logic [4:0]  imm;
        logic [31:0] rs1;
        logic [1:0]  wid;
        logic        pid;
        logic        err;
        logic [DW-1:0] data;
    } vec_t;

    rsp_t sb[$];
    rsp_t mon_e;
    vec_t vecs[24];
    int   n_checks = 0;
    int   n_fail = 0;
    int   waited;

    function automatic logic [DW-1:0] rep(input logic [31:0] v);
        return {4{v}};
    endfunction

    function automatic logic [DW-1:0] lanes(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr, input logic ui,
                                input logic [4:0] imm, input logic [31:0] rs1, input logic [1:0] wid,
                                input logic pid, input logic err, input logic [DW-1:0] data);
        vec_t v;
        v.op = op; v.addr = addr; v.ui = ui; v.imm = imm; v.rs1 = rs1;
        v.wid = wid; v.pid = pid; v.err = err; v.data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] op, input logic [11:0] addr, input logic ui,
                           input logic [4:0] imm, input logic [31:0] rs1, input logic [1:0] wid,
                           input logic pid, input logic [7:0] tag);
        bus.req_op = op; bus.req_addr = addr; bus.req_use_imm = ui; bus.req_imm = imm;
        bus.req_rs1 = rs1; bus.req_wid = wid; bus.req_pid = pid; bus.req_tag = tag;
    endtask

    // Hold req_valid until accepted (bounded), queue the expected response
    task automatic wait_accept(input string name, input logic err, input logic [DW-1:0] data,
                               output int cycles);
        rsp_t e;
        bit ok = 0;
        cycles = 0;
        bus.req_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1;
                break;
            end
            cycles++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no accept within 50 cycles expected accept", name);
        end else begin
            e.tag = bus.req_tag; e.wid = bus.req_wid; e.err = err; e.data = data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100; c++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d responses outstanding expected 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pop and compare on every completed response handshake
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got tag %h expected none", bus.rsp_tag);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_tag", DW'(bus.rsp_tag), DW'(mon_e.tag));
                check("rsp_wid", DW'(bus.rsp_wid), DW'(mon_e.wid));
                check("rsp_err", DW'(bus.rsp_err), DW'(mon_e.err));
                check("rsp_data", bus.rsp_data, mon_e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.alm_empty = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(2'd0, 12'hBC0, 1'b0, 5'd0, 32'd0, 2'd3, 1'b0, 8'h00);

        // scratch: RW/RS/RC semantics, zero-source suppression, window bounds
        vecs[0]  = mk(2'd0, 12'hBC1, 0, 5'd0, 32'hA5A5_0000, 2'd2, 0, 0, rep(32'h0));
        vecs[1]  = mk(2'd1, 12'hBC1, 1, 5'd5, 32'hFFFF_FFFF, 2'd2, 0, 0, rep(32'hA5A5_0000));
        vecs[2]  = mk(2'd2, 12'hBC1, 0, 5'd0, 32'h0,         2'd2, 0, 0, rep(32'hA5A5_0005));
        vecs[3]  = mk(2'd2, 12'hBC1, 0, 5'd0, 32'h5,         2'd2, 0, 0, rep(32'hA5A5_0005));
        vecs[4]  = mk(2'd1, 12'hBC1, 0, 5'd0, 32'h0,         2'd2, 0, 0, rep(32'hA5A5_0000));
        vecs[5]  = mk(2'd0, 12'hBC1, 0, 5'd0, 32'h1234,      2'd1, 0, 0, rep(32'h0));
        vecs[6]  = mk(2'd1, 12'hBC1, 0, 5'd0, 32'h0,         2'd2, 0, 0, rep(32'hA5A5_0000));
        vecs[7]  = mk(2'd1, 12'hBC1, 0, 5'd0, 32'h0,         2'd1, 0, 0, rep(32'h1234));
        vecs[8]  = mk(2'd0, 12'hBC7, 0, 5'd0, 32'hFFFF_FFFF, 2'd0, 0, 0, rep(32'h0));
        vecs[9]  = mk(2'd0, 12'hBC7, 1, 5'd3, 32'hFFFF_FFFF, 2'd0, 0, 0, rep(32'hFFFF_FFFF));
        vecs[10] = mk(2'd1, 12'hBC7, 0, 5'd0, 32'h0,         2'd0, 0, 0, rep(32'h3));
        vecs[11] = mk(2'd0, 12'hBC8, 0, 5'd0, 32'h7,         2'd0, 0, 1, rep(32'h0));
        vecs[12] = mk(2'd0, 12'hBBF, 0, 5'd0, 32'h7,         2'd0, 0, 1, rep(32'h0));
        vecs[13] = mk(2'd0, 12'hBC0, 0, 5'd0, 32'hF0,        2'd3, 0, 0, rep(32'h0));
        vecs[14] = mk(2'd3, 12'hBC0, 0, 5'd0, 32'h30,        2'd3, 0, 0, rep(32'hF0));
        vecs[15] = mk(2'd1, 12'hBC0, 0, 5'd0, 32'h0,         2'd3, 0, 0, rep(32'hC0));
        // thread / hart IDs (CORE_ID=1), unknown and fenced addresses
        vecs[16] = mk(2'd0, 12'hCC0, 0, 5'd0, 32'hFF,        2'd0, 1, 0, lanes(32'h4));
        vecs[17] = mk(2'd1, 12'hCC0, 0, 5'd0, 32'h0,         2'd2, 0, 0, lanes(32'h0));
        vecs[18] = mk(2'd0, 12'hF14, 0, 5'd0, 32'hFF,        2'd3, 0, 0, lanes(32'h38));
        vecs[19] = mk(2'd1, 12'hF14, 0, 5'd0, 32'h0,         2'd3, 1, 0, lanes(32'h3C));
        vecs[20] = mk(2'd1, 12'hF14, 0, 5'd0, 32'h0,         2'd0, 0, 0, lanes(32'h20));
        vecs[21] = mk(2'd1, 12'h7FF, 0, 5'd0, 32'h0,         2'd1, 0, 1, rep(32'h0));
        vecs[22] = mk(2'd0, 12'h003, 0, 5'd0, 32'h1,         2'd1, 0, 1, rep(32'h0));
        vecs[23] = mk(2'd1, 12'hBC0, 0, 5'd0, 32'h0,         2'd0, 0, 0, rep(32'h0));

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("reset_rsp_err", DW'(bus.rsp_err), DW'(0));
        check("reset_rsp_data", bus.rsp_data, '0);
        check("reset_req_ready", DW'(bus.req_ready), DW'(1));
        check("reset_alm_wid", DW'(bus.alm_empty_wid), DW'(3));
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            set_req(vecs[i].op, vecs[i].addr, vecs[i].ui, vecs[i].imm, vecs[i].rs1,
                    vecs[i].wid, vecs[i].pid, 8'(i + 1));
            wait_accept("vec_accept", vecs[i].err, vecs[i].data, waited);
        end
        drain("vec_drain");

        // fenced request waits for the warp to drain
        bus.alm_empty = 1'b0;
        set_req(2'd0, 12'h001, 0, 5'd0, 32'h0, 2'd2, 0, 8'h50);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fence_req_ready", DW'(bus.req_ready), DW'(0));
            check("fence_alm_wid", DW'(bus.alm_empty_wid), DW'(2));
            if (k > 0) check("fence_state", DW'(dut.state), DW'(1));
            @(posedge clk);
            #1;
        end
        bus.alm_empty = 1'b1;
        @(negedge clk);
        check("fence_exit_ready", DW'(bus.req_ready), DW'(0));
        @(posedge clk);
        #1;
        wait_accept("fence_accept", 1'b1, rep(32'h0), waited);
        check("fence_accept_latency", DW'(waited), DW'(0));
        drain("fence_drain");
        repeat (3) @(negedge clk);
        check("fence_single_rsp", DW'(bus.rsp_valid), DW'(0));
        @(posedge clk);
        #1;

        // back-pressure: four fill the FIFO, fifth waits for a pop
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            set_req(2'd1, 12'hCC0, 0, 5'd0, 32'h0, 2'd0, 0, 8'(8'hA0 + t));
            wait_accept("fill_accept", 1'b0, lanes(32'h0), waited);
        end
        set_req(2'd1, 12'hCC0, 0, 5'd0, 32'h0, 2'd1, 1, 8'hA4);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_req_ready", DW'(bus.req_ready), DW'(0));
            check("full_rsp_stable", DW'(bus.rsp_tag), DW'(8'hA0));
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("full_no_bypass", DW'(bus.req_ready), DW'(0));
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        wait_accept("fifth_accept", 1'b0, lanes(32'h4), waited);
        check("fifth_latency", DW'(waited), DW'(0));
        bus.rsp_ready = 1'b1;
        drain("full_drain");

        // reset while fenced with two responses queued
        bus.rsp_ready = 1'b0;
        set_req(2'd0, 12'hBC2, 0, 5'd0, 32'h77, 2'd1, 0, 8'hC0);
        wait_accept("pre_reset_a", 1'b0, rep(32'h0), waited);
        set_req(2'd0, 12'hBC3, 0, 5'd0, 32'h88, 2'd1, 0, 8'hC1);
        wait_accept("pre_reset_b", 1'b0, rep(32'h0), waited);
        bus.alm_empty = 1'b0;
        set_req(2'd0, 12'h002, 0, 5'd0, 32'h0, 2'd3, 0, 8'hC2);
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_reset_state", DW'(dut.state), DW'(1));
        check("pre_reset_alm_wid", DW'(bus.alm_empty_wid), DW'(3));
        check("pre_reset_rsp_valid", DW'(bus.rsp_valid), DW'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(2'd1, 12'hBC2, 0, 5'd0, 32'h0, 2'd1, 0, 8'hC3);
        @(negedge clk);
        check("post_reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        check("post_reset_rsp_err", DW'(bus.rsp_err), DW'(0));
        check("post_reset_rsp_data", bus.rsp_data, '0);
        check("post_reset_state", DW'(dut.state), DW'(0));
        check("post_reset_req_ready", DW'(bus.req_ready), DW'(1));
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_accept("post_reset_bc2", 1'b0, rep(32'h0), waited);
        set_req(2'd1, 12'hBC1, 0, 5'd0, 32'h0, 2'd2, 0, 8'hC4);
        wait_accept("post_reset_bc1", 1'b0, rep(32'h0), waited);
        bus.alm_empty = 1'b1;
        drain("reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vx_csr_pipe.md
VX_CSR_PIPE -- requirements
Module: vx_csr_pipe

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: lanes per request.
REQ-002 SHALL have parameter NUM_THREADS, default 8: threads per warp; PID_BITS = clog2(NUM_THREADS/NUM_LANES), PID_W = max(PID_BITS,1).
REQ-003 SHALL have parameter NUM_WARPS, default 4: NW_BITS = max(clog2(NUM_WARPS),1).
REQ-004 SHALL have parameter XLEN, default 32: data width.
REQ-005 SHALL have parameter NUM_CSRS, default 8: per-warp scratch CSRs at CSR_BASE..CSR_BASE+NUM_CSRS-1.
REQ-006 SHALL have parameter CSR_BASE, default 12'hBC0: scratch window base.
REQ-007 SHALL have parameter FENCE_LIMIT, default 12'h003: addresses <= FENCE_LIMIT are fenced.
REQ-008 SHALL have parameter RSP_DEPTH, default 4: response FIFO depth, >= 2.
REQ-009 SHALL have parameter TAG_W, default 8: request tag width.
REQ-010 SHALL have parameter CORE_ID, default 0: core index for hart ID.
REQ-011 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-012 SHALL have ports req_valid in 1; req_ready out 1; req_op in 2 (0 RW, 1 RS, 2 RC, 3 reserved = RC); req_addr in 12; req_use_imm in 1; req_imm in 5; req_rs1 in XLEN (lane 0 operand); req_wid in NW_BITS; req_pid in PID_W; req_tag in TAG_W.
REQ-013 SHALL have ports alm_empty in 1 (warp alm_empty_wid has no pending instructions); alm_empty_wid out NW_BITS.
REQ-014 SHALL have ports rsp_valid out 1; rsp_ready in 1; rsp_tag out TAG_W; rsp_wid out NW_BITS; rsp_err out 1; rsp_data out NUM_LANES*XLEN.

Function
REQ-015 SHALL run FSM IDLE/FENCE; transfer occurs on req_valid && req_ready.
REQ-016 In IDLE, a valid fenced request with alm_empty=0 SHALL hold req_ready=0, latch wid, and move to FENCE.
REQ-017 In FENCE, alm_empty_wid SHALL equal the latched wid, req_ready SHALL be 0, and the FSM SHALL return to IDLE the cycle after alm_empty=1.
REQ-018 In IDLE, alm_empty_wid SHALL equal req_wid; req_ready = (FIFO count < RSP_DEPTH) && (not fenced || alm_empty).
REQ-019 Full FIFO SHALL deassert req_ready even if rsp_ready=1 in that cycle (no pop bypass).
REQ-020 Source operand src = req_use_imm ? zero-extended req_imm : req_rs1.
REQ-021 Scratch read SHALL return old value of csr[wid][addr-CSR_BASE] in all lanes; write value: RW src, RS old|src, RC old&~src.
REQ-022 Write SHALL occur at transfer edge; RS/RC with src==0 SHALL NOT write; RW always writes.
REQ-023 Back-to-back transfers to the same warp/address SHALL see the previous write (no stale read).
REQ-024 Address 12'hCC0 SHALL return lane i = pid*NUM_LANES+i (pid term 0 if PID_BITS==0); 12'hF14 SHALL return (CORE_ID<<(NW_BITS+clog2(NUM_THREADS))) + (wid<<clog2(NUM_THREADS)) + lane value; writes to both ignored.
REQ-025 Any other address SHALL return 0, perform no write, set rsp_err=1.
REQ-026 Each transfer SHALL push {tag,wid,err,data} into the FIFO; rsp_valid = FIFO non-empty; pop on rsp_valid && rsp_ready; order preserved; earliest rsp_valid one cycle after transfer.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; rsp_* SHALL stay stable while rsp_valid && !rsp_ready.

Reset
REQ-028 Reset SHALL force IDLE, empty FIFO, rsp_valid=0, rsp_err=0, rsp_data=0, all scratch CSRs 0; latched wid 0.
REQ-029 Reset mid-FENCE or with FIFO non-empty SHALL discard all pending state; req_ready valid per REQ-018 the cycle after reset deasserts.

Verification
REQ-030 Bench SHALL cover: RW 0xBC1 wid=2 rs1=0xA5A5_0000, then RS imm=5 -> rsp0 data 0, rsp1 data 0xA5A5_0000, csr=0xA5A5_0005.
REQ-031 Bench SHALL cover: RC 0xBC1 wid=2 rs1=0 -> returns old value, no write; RC rs1=0x5 -> csr=0xA5A5_0000.
REQ-032 Bench SHALL cover: fenced addr 0x001 with alm_empty=0 for 5 cycles -> req_ready=0, state FENCE, alm_empty_wid=req wid; alm_empty=1 -> accepted, one response.
REQ-033 Bench SHALL cover: rsp_ready=0, 4 requests (RSP_DEPTH=4) -> 5th stalls; one pop -> 5th accepted next cycle; tags returned in order.
REQ-034 Bench SHALL cover: 0xCC0 pid=1 -> lanes 4,5,6,7; 0xF14 CORE_ID=1 wid=3 pid=0 -> 0x38..0x3B (NW_BITS=2, clog2(NUM_THREADS)=3); addr 0x7FF -> rsp_err=1, data 0.
REQ-035 Bench SHALL cover: reset asserted in FENCE with 2 queued responses -> rsp_valid=0 next cycle, scratch read returns 0.
